// File: rtl/dm_store_ctrl.sv
// dm_store_ctrl: MEM-stage store controller driving byte-lane data and
// active-low byte write enables to the data memory. Word-crossing stores
// are either split into two word writes (EX stalled meanwhile) or dropped
// with a one-cycle misalign_err pulse, depending on MISALIGN_SPLIT.
module dm_store_ctrl #(
  parameter int ADDR_W         = 14,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              store_valid,
  input  logic [1:0]        store_type,
  input  logic [31:0]       store_addr,
  input  logic [31:0]       store_data,
  input  logic              dm_ready,
  output logic              stall_o,
  output logic              DM_CEB,
  output logic [3:0]        DM_WEB,
  output logic [ADDR_W-1:0] DM_A,
  output logic [31:0]       DM_DI,
  output logic              misalign_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;

  // Decoded view of the store currently presented by EX
  logic [3:0]        size_mask;
  logic [31:0]       data_masked;
  logic [1:0]        off;
  logic [ADDR_W-1:0] word;
  logic [7:0]        lane_mask;
  logic [63:0]       lane_data;
  logic              split;
  logic              drop;
  logic              accept;
  logic              take;
  logic              unused_addr;

  // Second half of a split store, parked until the low write is taken
  logic              split_q;
  logic [ADDR_W-1:0] hi_a;
  logic [3:0]        hi_web;
  logic [31:0]       hi_di;

  // Next values of every registered output / holding register
  logic              ceb_next;
  logic [3:0]        web_next;
  logic [ADDR_W-1:0] a_next;
  logic [31:0]       di_next;
  logic              misalign_next;
  logic              split_next;
  logic [ADDR_W-1:0] hi_a_next;
  logic [3:0]        hi_web_next;
  logic [31:0]       hi_di_next;

  // Byte-count mask and store data trimmed to the bytes actually stored
  always_comb begin
    size_mask   = 4'b0000;
    data_masked = 32'h0;
    case (store_type)
      2'b01: begin
        size_mask   = 4'b0001;
        data_masked = {24'h0, store_data[7:0]};
      end
      2'b10: begin
        size_mask   = 4'b0011;
        data_masked = {16'h0, store_data[15:0]};
      end
      2'b11: begin
        size_mask   = 4'b1111;
        data_masked = store_data;
      end
      default: begin
        size_mask   = 4'b0000;
        data_masked = 32'h0;
      end
    endcase
  end

  assign off         = store_addr[1:0];
  assign word        = store_addr[ADDR_W+1:2];
  assign lane_mask   = {4'b0000, size_mask} << off;
  assign lane_data   = {32'h0, data_masked} << {off, 3'b000};
  assign split       = |lane_mask[7:4];
  assign drop        = (MISALIGN_SPLIT == 1'b0) && split;
  assign unused_addr = ^store_addr[31:ADDR_W+2];

  assign stall_o = ((state == WR_LO) && (!dm_ready || split_q)) ||
                   ((state == WR_HI) && !dm_ready);
  assign accept  = store_valid && (store_type != 2'b00) && !stall_o;
  assign take    = accept && !drop;

  // State register; reset aborts any store in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: chain low writes back-to-back, detour through WR_HI for splits
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take) state_next = WR_LO;
      end
      WR_LO: begin
        if (dm_ready) begin
          if (split_q)   state_next = WR_HI;
          else if (take) state_next = WR_LO;
          else           state_next = IDLE;
        end
      end
      WR_HI: begin
        if (dm_ready) begin
          if (take) state_next = WR_LO;
          else      state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: load a low write, issue the parked high write, or go quiet
  always_comb begin
    ceb_next      = DM_CEB;
    web_next      = DM_WEB;
    a_next        = DM_A;
    di_next       = DM_DI;
    misalign_next = accept && drop;
    split_next    = split_q;
    hi_a_next     = hi_a;
    hi_web_next   = hi_web;
    hi_di_next    = hi_di;
    if (take) begin
      ceb_next    = 1'b0;
      web_next    = ~lane_mask[3:0];
      a_next      = word;
      di_next     = lane_data[31:0];
      split_next  = split;
      hi_a_next   = word + WORD_ONE;
      hi_web_next = ~lane_mask[7:4];
      hi_di_next  = lane_data[63:32];
    end else if ((state == WR_LO) && dm_ready && split_q) begin
      ceb_next   = 1'b0;
      web_next   = hi_web;
      a_next     = hi_a;
      di_next    = hi_di;
      split_next = 1'b0;
    end else if ((state != IDLE) && dm_ready) begin
      ceb_next   = 1'b1;
      web_next   = 4'hF;
      split_next = 1'b0;
    end
  end

  // DM strobe and holding registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DM_CEB       <= 1'b1;
      DM_WEB       <= 4'hF;
      DM_A         <= '0;
      DM_DI        <= 32'h0;
      misalign_err <= 1'b0;
      split_q      <= 1'b0;
      hi_a         <= '0;
      hi_web       <= 4'hF;
      hi_di        <= 32'h0;
    end else begin
      DM_CEB       <= ceb_next;
      DM_WEB       <= web_next;
      DM_A         <= a_next;
      DM_DI        <= di_next;
      misalign_err <= misalign_next;
      split_q      <= split_next;
      hi_a         <= hi_a_next;
      hi_web       <= hi_web_next;
      hi_di        <= hi_di_next;
    end
  end

endmodule

// File: tb/tb_dm_store_ctrl.sv
// tb_dm_store_ctrl: directed bench for dm_store_ctrl with a write scoreboard.
// Expected DM writes are built byte-by-byte from each store and queued when
// the store is driven; every write DM takes is popped and compared.
module tb_dm_store_ctrl;

  localparam int ADDR_W = 14;

  typedef logic [ADDR_W+36-1:0] wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              store_valid;
  logic [1:0]        store_type;
  logic [31:0]       store_addr;
  logic [31:0]       store_data;
  logic              dm_ready;
  logic              stall_o;
  logic              DM_CEB;
  logic [3:0]        DM_WEB;
  logic [ADDR_W-1:0] DM_A;
  logic [31:0]       DM_DI;
  logic              misalign_err;

  logic              ns_valid;
  logic [1:0]        ns_type;
  logic [31:0]       ns_addr;
  logic [31:0]       ns_data;
  logic              ns_stall;
  logic              ns_ceb;
  logic [3:0]        ns_web;
  logic [ADDR_W-1:0] ns_a;
  logic [31:0]       ns_di;
  logic              ns_misalign;

  wr_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  dm_store_ctrl #(.ADDR_W(ADDR_W), .MISALIGN_SPLIT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .store_valid(store_valid), .store_type(store_type),
    .store_addr(store_addr), .store_data(store_data),
    .dm_ready(dm_ready), .stall_o(stall_o),
    .DM_CEB(DM_CEB), .DM_WEB(DM_WEB), .DM_A(DM_A), .DM_DI(DM_DI),
    .misalign_err(misalign_err)
  );

  dm_store_ctrl #(.ADDR_W(ADDR_W), .MISALIGN_SPLIT(1'b0)) dut_nosplit (
    .clk(clk), .rst(rst),
    .store_valid(ns_valid), .store_type(ns_type),
    .store_addr(ns_addr), .store_data(ns_data),
    .dm_ready(1'b1), .stall_o(ns_stall),
    .DM_CEB(ns_ceb), .DM_WEB(ns_web), .DM_A(ns_a), .DM_DI(ns_di),
    .misalign_err(ns_misalign)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    assert (actual === expected) else begin
      failures++;
      $error("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of EX/DM inputs shortly after the rising edge
  task automatic applyStimulus(input logic v, input logic [1:0] t,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic r);
    @(posedge clk);
    #2;
    store_valid = v;
    store_type  = t;
    store_addr  = a;
    store_data  = d;
    dm_ready    = r;
  endtask

  // Queue the word writes a store should produce, walking its bytes one at a time
  task automatic pushStore(input logic [1:0] t, input logic [31:0] a,
                           input logic [31:0] d);
    int                n;
    int                pos;
    bit                has_hi;
    logic [ADDR_W-1:0] w_lo;
    logic [ADDR_W-1:0] w_hi;
    logic [3:0]        web_lo;
    logic [3:0]        web_hi;
    logic [31:0]       di_lo;
    logic [31:0]       di_hi;
    n      = (t == 2'b01) ? 1 : ((t == 2'b10) ? 2 : 4);
    w_lo   = a[ADDR_W+1:2];
    w_hi   = w_lo + 1'b1;
    web_lo = 4'hF;
    web_hi = 4'hF;
    di_lo  = 32'h0;
    di_hi  = 32'h0;
    has_hi = 1'b0;
    for (int k = 0; k < n; k++) begin
      pos = int'(a[1:0]) + k;
      if (pos < 4) begin
        web_lo[pos]          = 1'b0;
        di_lo[8*pos +: 8]    = d[8*k +: 8];
      end else begin
        web_hi[pos-4]        = 1'b0;
        di_hi[8*(pos-4) +: 8] = d[8*k +: 8];
        has_hi               = 1'b1;
      end
    end
    sb.push_back({w_lo, web_lo, di_lo});
    if (has_hi) sb.push_back({w_hi, web_hi, di_hi});
  endtask

  // Scoreboard: every write DM takes must match the oldest queued write
  always @(negedge clk) begin
    wr_t exp_wr;
    if (!rst && !DM_CEB && dm_ready) begin
      if (sb.size() > 0) exp_wr = sb.pop_front();
      else               exp_wr = 'x;
      checkOutput("dm_write", 64'({DM_A, DM_WEB, DM_DI}), 64'(exp_wr));
    end
  end

  initial begin
    store_valid = 1'b0;
    store_type  = 2'b00;
    store_addr  = 32'h0;
    store_data  = 32'h0;
    dm_ready    = 1'b1;
    ns_valid    = 1'b0;
    ns_type     = 2'b00;
    ns_addr     = 32'h0;
    ns_data     = 32'h0;
    rst         = 1'b1;

    @(negedge clk);
    checkOutput("rst_ceb",      64'(DM_CEB),       64'h1);
    checkOutput("rst_web",      64'(DM_WEB),       64'hF);
    checkOutput("rst_a",        64'(DM_A),         64'h0);
    checkOutput("rst_di",       64'(DM_DI),        64'h0);
    checkOutput("rst_misalign", 64'(misalign_err), 64'h0);
    checkOutput("rst_stall",    64'(stall_o),      64'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    $display("[TB] store_type 00 is ignored");
    applyStimulus(1'b1, 2'b00, 32'h104, 32'hDEAD, 1'b1);
    @(negedge clk);
    checkOutput("none_stall", 64'(stall_o), 64'h0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("none_ceb", 64'(DM_CEB), 64'h1);

    $display("[TB] T1 SB to lane 3");
    pushStore(2'b01, 32'h103, 32'h55AB);
    applyStimulus(1'b1, 2'b01, 32'h103, 32'h55AB, 1'b1);
    @(negedge clk);
    checkOutput("t1_stall_idle", 64'(stall_o), 64'h0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t1_ceb", 64'(DM_CEB), 64'h0);
    checkOutput("t1_a",   64'(DM_A),   64'h40);
    checkOutput("t1_web", 64'(DM_WEB), 64'h7);
    checkOutput("t1_di",  64'(DM_DI),  64'hAB000000);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t1_ceb_idle", 64'(DM_CEB), 64'h1);
    checkOutput("t1_web_idle", 64'(DM_WEB), 64'hF);

    $display("[TB] T2 SH to upper half");
    pushStore(2'b10, 32'h2, 32'hFFFF1234);
    applyStimulus(1'b1, 2'b10, 32'h2, 32'hFFFF1234, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t2_stall", 64'(stall_o), 64'h0);
    checkOutput("t2_di",    64'(DM_DI),   64'h12340000);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);

    $display("[TB] T3 split SW");
    pushStore(2'b11, 32'h7, 32'hAABBCCDD);
    applyStimulus(1'b1, 2'b11, 32'h7, 32'hAABBCCDD, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t3_lo_stall", 64'(stall_o), 64'h1);
    checkOutput("t3_lo_a",     64'(DM_A),    64'h1);
    checkOutput("t3_lo_web",   64'(DM_WEB),  64'h7);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t3_hi_stall", 64'(stall_o), 64'h0);
    checkOutput("t3_hi_a",     64'(DM_A),    64'h2);
    checkOutput("t3_hi_web",   64'(DM_WEB),  64'h8);
    checkOutput("t3_hi_di",    64'(DM_DI),   64'h00AABBCC);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t3_ceb_idle", 64'(DM_CEB), 64'h1);

    $display("[TB] T4 back-to-back SW with dm_ready low");
    pushStore(2'b11, 32'h0, 32'h01020304);
    applyStimulus(1'b1, 2'b11, 32'h0, 32'h01020304, 1'b0);
    @(negedge clk);
    checkOutput("t4_stall_idle", 64'(stall_o), 64'h0);
    pushStore(2'b11, 32'h4, 32'h0A0B0C0D);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b11, 32'h4, 32'h0A0B0C0D, 1'b0);
      @(negedge clk);
      checkOutput("t4_stall_hold", 64'(stall_o), 64'h1);
      checkOutput("t4_a_hold",     64'(DM_A),    64'h0);
      checkOutput("t4_ceb_hold",   64'(DM_CEB),  64'h0);
    end
    applyStimulus(1'b1, 2'b11, 32'h4, 32'h0A0B0C0D, 1'b1);
    @(negedge clk);
    checkOutput("t4_stall_rel", 64'(stall_o), 64'h0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t4_a_second",   64'(DM_A),   64'h1);
    checkOutput("t4_ceb_second", 64'(DM_CEB), 64'h0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t4_ceb_idle", 64'(DM_CEB), 64'h1);

    $display("[TB] T5 split SW wrapping the word address");
    pushStore(2'b11, 32'hFFFE, 32'h11223344);
    applyStimulus(1'b1, 2'b11, 32'hFFFE, 32'h11223344, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t5_lo_a",   64'(DM_A),   64'h3FFF);
    checkOutput("t5_lo_web", 64'(DM_WEB), 64'h3);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t5_hi_a",   64'(DM_A),   64'h0);
    checkOutput("t5_hi_web", 64'(DM_WEB), 64'hC);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);

    $display("[TB] T6 reset while the high write is pending");
    pushStore(2'b11, 32'h7, 32'hCAFEBABE);
    applyStimulus(1'b1, 2'b11, 32'h7, 32'hCAFEBABE, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("t6_hi_ceb",   64'(DM_CEB),  64'h0);
    checkOutput("t6_hi_web",   64'(DM_WEB),  64'h8);
    checkOutput("t6_hi_stall", 64'(stall_o), 64'h1);
    #1 rst = 1'b1;
    #1;
    checkOutput("t6_rst_ceb",   64'(DM_CEB),  64'h1);
    checkOutput("t6_rst_web",   64'(DM_WEB),  64'hF);
    checkOutput("t6_rst_stall", 64'(stall_o), 64'h0);
    sb.delete();
    @(posedge clk);
    #2;
    rst      = 1'b0;
    dm_ready = 1'b1;
    @(negedge clk);
    checkOutput("t6_post_ceb", 64'(DM_CEB), 64'h1);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t6_post_ceb2", 64'(DM_CEB), 64'h1);

    $display("[TB] MISALIGN_SPLIT=0 drops word-crossing stores");
    @(posedge clk);
    #2;
    ns_valid = 1'b1;
    ns_type  = 2'b11;
    ns_addr  = 32'h7;
    ns_data  = 32'hAABBCCDD;
    @(negedge clk);
    checkOutput("ns_stall", 64'(ns_stall), 64'h0);
    @(posedge clk);
    #2 ns_valid = 1'b0;
    @(negedge clk);
    checkOutput("ns_err_pulse", 64'(ns_misalign), 64'h1);
    checkOutput("ns_no_write",  64'(ns_ceb),      64'h1);
    @(posedge clk);
    #2;
    @(negedge clk);
    checkOutput("ns_err_clear", 64'(ns_misalign), 64'h0);
    checkOutput("ns_ceb_idle",  64'(ns_ceb),      64'h1);
    @(posedge clk);
    #2;
    ns_valid = 1'b1;
    ns_type  = 2'b11;
    ns_addr  = 32'h8;
    ns_data  = 32'h5A5AA5A5;
    @(negedge clk);
    @(posedge clk);
    #2 ns_valid = 1'b0;
    @(negedge clk);
    checkOutput("ns_al_ceb", 64'(ns_ceb),      64'h0);
    checkOutput("ns_al_a",   64'(ns_a),        64'h2);
    checkOutput("ns_al_web", 64'(ns_web),      64'h0);
    checkOutput("ns_al_di",  64'(ns_di),       64'h5A5AA5A5);
    checkOutput("ns_al_err", 64'(ns_misalign), 64'h0);

    checkOutput("sb_drained", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
